// File: rtl/u409_tack_engine.sv
// Transfer-ack engine for U409: terminates 68040/060 bus cycles for NCH address-space channels.
// Optional build macro U409_TEA_ON_TIMEOUT_EN adds TEA_OUTn for watchdog terminations.
module u409_tack_engine #(
    parameter int unsigned NCH      = 6,
    parameter int unsigned DW       = 4,
    parameter int unsigned WDW      = 7,
    parameter int unsigned WD_LIMIT = 125
) (
    input  logic              CLK40,
    input  logic              DELAYED_TACK_RST,
    input  logic              TSn,
    input  logic [NCH-1:0]    CH_SEL,
    input  logic [NCH*DW-1:0] CH_DELAY,
    input  logic [NCH-1:0]    CH_NOCACHE,
    input  logic              EXT_TACK,
    input  logic              TACKn_IN,
    output logic              TACK_OE,
    output logic              TACK_OUTn,
    output logic              TCI_OUTn,
    output logic [3:0]        ACTIVE_CH,
    output logic              BUSY,
    output logic              TIMEOUT_FLAG
`ifdef U409_TEA_ON_TIMEOUT_EN
    ,
    output logic              TEA_OUTn
`endif
);

`ifdef U409_TEA_ON_TIMEOUT_EN
    localparam bit TeaEn = 1'b1;
`else
    localparam bit TeaEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StCount, StWait, StAssert, StNegate, StRelease} state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [3:0]     ch_q, ch_d;
    logic           tci_low_q, tci_low_d;
    logic           wd_term_q, wd_term_d;
    logic           timeout_q, timeout_d;
    logic           oe_q, tack_q, tci_q, busy_q;
    logic           oe_d, tack_d, tci_d, busy_d, assert_d;

    logic [3:0]     hit_idx;
    logic [DW-1:0]  hit_delay;
    logic           ch_nc;

    // Descending scan so the lowest set channel is the one left standing.
    always_comb begin
        hit_idx   = '0;
        hit_delay = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (CH_SEL[i]) begin
                hit_idx   = 4'(i);
                hit_delay = CH_DELAY[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ch_nc = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == 4'(i)) ch_nc = CH_NOCACHE[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        ch_d      = ch_q;
        tci_low_d = tci_low_q;
        wd_term_d = wd_term_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                wd_d = '0;
                if (!TSn) begin
                    wd_d = WDW'(1);
                    if (|CH_SEL) begin
                        ch_d    = hit_idx;
                        cnt_d   = hit_delay;
                        state_d = StCount;
                    end else begin
                        state_d = StWait;
                    end
                end else if (EXT_TACK) begin
                    tci_low_d = 1'b1;
                    wd_term_d = 1'b0;
                    state_d   = StAssert;
                end
            end
            StCount: begin
                // Channel expiry beats a coincident watchdog expiry.
                if (!TACKn_IN) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    tci_low_d = ch_nc;
                    wd_term_d = 1'b0;
                    state_d   = StAssert;
                end else if (wd_q == WDW'(WD_LIMIT)) begin
                    timeout_d = 1'b1;
                    tci_low_d = 1'b1;
                    wd_term_d = 1'b1;
                    state_d   = StAssert;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                    wd_d  = wd_q + WDW'(1);
                end
            end
            StWait: begin
                if (!TACKn_IN) begin
                    state_d = StIdle;
                end else if (wd_q == WDW'(WD_LIMIT)) begin
                    timeout_d = 1'b1;
                    tci_low_d = 1'b1;
                    wd_term_d = 1'b1;
                    state_d   = StAssert;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            StAssert:  state_d = StNegate;
            StNegate:  state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Bus outputs are registered from the next state so they come straight off flops.
    always_comb begin
        assert_d = (state_d == StAssert);
        oe_d     = assert_d || (state_d == StNegate);
        busy_d   = (state_d == StCount) || (state_d == StWait) || oe_d;
        tack_d   = !(assert_d && !(TeaEn && wd_term_d));
        tci_d    = !(assert_d && tci_low_d);
    end

    always_ff @(posedge CLK40 or posedge DELAYED_TACK_RST) begin
        if (DELAYED_TACK_RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wd_q      <= '0;
            ch_q      <= '0;
            tci_low_q <= 1'b0;
            wd_term_q <= 1'b0;
            timeout_q <= 1'b0;
            oe_q      <= 1'b0;
            tack_q    <= 1'b1;
            tci_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            ch_q      <= ch_d;
            tci_low_q <= tci_low_d;
            wd_term_q <= wd_term_d;
            timeout_q <= timeout_d;
            oe_q      <= oe_d;
            tack_q    <= tack_d;
            tci_q     <= tci_d;
            busy_q    <= busy_d;
        end
    end

`ifdef U409_TEA_ON_TIMEOUT_EN
    logic tea_q;

    always_ff @(posedge CLK40 or posedge DELAYED_TACK_RST) begin
        if (DELAYED_TACK_RST) tea_q <= 1'b1;
        else                  tea_q <= !((state_d == StAssert) && wd_term_d);
    end

    assign TEA_OUTn = tea_q;
`endif

    assign TACK_OE      = oe_q;
    assign TACK_OUTn    = tack_q;
    assign TCI_OUTn     = tci_q;
    assign ACTIVE_CH    = ch_q;
    assign BUSY         = busy_q;
    assign TIMEOUT_FLAG = timeout_q;

endmodule

// File: tb/tb_u409_tack_engine.sv
// Bench for u409_tack_engine: two instances (WD_LIMIT 125 and 15) checked cycle by cycle
// against a timeline model derived from channel delays, watchdog limit and abort points.
module tb_u409_tack_engine;

`ifdef U409_TEA_ON_TIMEOUT_EN
    localparam bit TEA = 1'b1;
`else
    localparam bit TEA = 1'b0;
`endif

    logic        CLK40 = 1'b0;
    logic        DELAYED_TACK_RST;
    logic        TSn;
    logic [5:0]  CH_SEL;
    logic [23:0] CH_DELAY;
    logic [5:0]  CH_NOCACHE;
    logic        EXT_TACK;
    logic        TACKn_IN;

    logic oe_a, tack_a, tci_a, busy_a, flag_a, tea_a;
    logic oe_b, tack_b, tci_b, busy_b, flag_b, tea_b;
    logic [3:0] ch_a, ch_b;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] ch_m = 4'h0;
    bit mflag_a = 1'b0;
    bit mflag_b = 1'b0;

    always #5 CLK40 = ~CLK40;

    u409_tack_engine u_dut_a (
        .CLK40            (CLK40),
        .DELAYED_TACK_RST (DELAYED_TACK_RST),
        .TSn              (TSn),
        .CH_SEL           (CH_SEL),
        .CH_DELAY         (CH_DELAY),
        .CH_NOCACHE       (CH_NOCACHE),
        .EXT_TACK         (EXT_TACK),
        .TACKn_IN         (TACKn_IN),
        .TACK_OE          (oe_a),
        .TACK_OUTn        (tack_a),
        .TCI_OUTn         (tci_a),
        .ACTIVE_CH        (ch_a),
        .BUSY             (busy_a),
        .TIMEOUT_FLAG     (flag_a)
`ifdef U409_TEA_ON_TIMEOUT_EN
        ,
        .TEA_OUTn         (tea_a)
`endif
    );

    u409_tack_engine #(
        .WD_LIMIT (15)
    ) u_dut_b (
        .CLK40            (CLK40),
        .DELAYED_TACK_RST (DELAYED_TACK_RST),
        .TSn              (TSn),
        .CH_SEL           (CH_SEL),
        .CH_DELAY         (CH_DELAY),
        .CH_NOCACHE       (CH_NOCACHE),
        .EXT_TACK         (EXT_TACK),
        .TACKn_IN         (TACKn_IN),
        .TACK_OE          (oe_b),
        .TACK_OUTn        (tack_b),
        .TCI_OUTn         (tci_b),
        .ACTIVE_CH        (ch_b),
        .BUSY             (busy_b),
        .TIMEOUT_FLAG     (flag_b)
`ifdef U409_TEA_ON_TIMEOUT_EN
        ,
        .TEA_OUTn         (tea_b)
`endif
    );

`ifndef U409_TEA_ON_TIMEOUT_EN
    assign tea_a = 1'b1;
    assign tea_b = 1'b1;
`endif

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%b exp=%b (busy,oe,tack,tci,tea,flag,ch)", tag, got, exp);
        end
    endtask

    // Termination plan: kind 0 = channel, 1 = watchdog, 2 = external; t = offset after TS edge.
    function automatic void plan(input logic [5:0] sel, input logic [23:0] dly, input int limit,
                                 output int t, output int kind, output logic [3:0] ch);
        int d;
        bit found;
        d = 0;
        found = 1'b0;
        ch = ch_m;
        for (int i = 0; i < 6; i++) begin
            if (sel[i] && !found) begin
                found = 1'b1;
                ch = 4'(i);
                d = int'(dly[i*4 +: 4]);
            end
        end
        if (found && (d + 1 <= limit)) begin
            t = d + 1;
            kind = 0;
        end else begin
            t = limit;
            kind = 1;
        end
    endfunction

    function automatic logic [9:0] expect_vec(input int j, input int t, input int kind,
                                              input bit nc, input int abort_j,
                                              input logic [3:0] ch, input bit flag0);
        bit ab, fl;
        logic b, o, tk, tc, te;
        ab = (kind != 2) && (abort_j > 0) && (abort_j <= t);
        fl = flag0 | ((kind == 1) && !ab && (j >= t));
        {b, o, tk, tc, te} = 5'b00111;
        if (ab && j >= abort_j) begin
            b = 1'b0;
        end else if (j < t) begin
            b = 1'b1;
        end else if (j == t) begin
            b  = 1'b1;
            o  = 1'b1;
            tk = (kind == 1) && TEA;
            tc = (kind == 0) ? !nc : 1'b0;
            te = !((kind == 1) && TEA);
        end else if (j == t + 1) begin
            b = 1'b1;
            o = 1'b1;
        end
        return {b, o, tk, tc, te, fl, (b ? ch : 4'h0)};
    endfunction

    task automatic txn(input logic [5:0] sel, input logic [23:0] dly, input logic [5:0] nc,
                       input bit ext_only, input bit ext_too, input int abort_j,
                       input int ts2_j);
        int ta, tb, ka, kb, ea, eb, last;
        logic [3:0] chn;
        bit ncb, aba, abb;
        logic [9:0] va, vb;
        if (ext_only) begin
            ta = 0; tb = 0; ka = 2; kb = 2; chn = ch_m; ncb = 1'b0;
        end else begin
            plan(sel, dly, 125, ta, ka, chn);
            plan(sel, dly, 15, tb, kb, chn);
            ncb = (sel != 6'h0) ? nc[chn[2:0]] : 1'b0;
        end
        aba = (ka != 2) && (abort_j > 0) && (abort_j <= ta);
        abb = (kb != 2) && (abort_j > 0) && (abort_j <= tb);
        ea = aba ? abort_j : ta + 3;
        eb = abb ? abort_j : tb + 3;
        last = ((ea > eb) ? ea : eb) + 2;
        TSn        = ext_only;
        EXT_TACK   = ext_only | ext_too;
        CH_SEL     = sel;
        CH_DELAY   = dly;
        CH_NOCACHE = nc;
        TACKn_IN   = 1'b1;
        for (int j = 0; j <= last; j++) begin
            @(posedge CLK40);
            @(negedge CLK40);
            va = expect_vec(j, ta, ka, ncb, abort_j, chn, mflag_a);
            vb = expect_vec(j, tb, kb, ncb, abort_j, chn, mflag_b);
            check($sformatf("A j=%0d", j),
                  {busy_a, oe_a, tack_a, tci_a, tea_a, flag_a, (va[9] ? ch_a : 4'h0)}, va);
            check($sformatf("B j=%0d", j),
                  {busy_b, oe_b, tack_b, tci_b, tea_b, flag_b, (vb[9] ? ch_b : 4'h0)}, vb);
            TSn      = (ts2_j == j + 1) ? 1'b0 : 1'b1;
            if (ts2_j == j + 1) CH_SEL = 6'b000001;
            EXT_TACK = 1'b0;
            TACKn_IN = (abort_j == j + 1) ? 1'b0 : 1'b1;
            CH_DELAY = 24'($urandom);
        end
        mflag_a = mflag_a | ((ka == 1) && !aba);
        mflag_b = mflag_b | ((kb == 1) && !abb);
        ch_m = chn;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " A"}, {busy_a, oe_a, tack_a, tci_a, tea_a, flag_a, ch_a}, 10'b0011100000);
        check({tag, " B"}, {busy_b, oe_b, tack_b, tci_b, tea_b, flag_b, ch_b}, 10'b0011100000);
    endtask

    task automatic do_reset();
        @(negedge CLK40);
        DELAYED_TACK_RST = 1'b1;
        TSn = 1'b1; EXT_TACK = 1'b0; TACKn_IN = 1'b1;
        #1;
        check_reset_state("reset");
        @(negedge CLK40);
        DELAYED_TACK_RST = 1'b0;
        mflag_a = 1'b0;
        mflag_b = 1'b0;
        ch_m = 4'h0;
        @(negedge CLK40);
        check_reset_state("post-reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [5:0] rsel;
        DELAYED_TACK_RST = 1'b0;
        TSn = 1'b1; CH_SEL = '0; CH_DELAY = '0; CH_NOCACHE = '0;
        EXT_TACK = 1'b0; TACKn_IN = 1'b1;
        #2;
        do_reset();

        // Single channel 2, delay 3: TACK low on the fourth edge after TS.
        txn(6'b000100, 24'h000300, 6'b000000, 1'b0, 1'b0, 0, 0);
        // Channel 1 beats channel 3; zero delay; no-cache drives TCIn.
        txn(6'b001010, 24'h007000, 6'b000010, 1'b0, 1'b0, 0, 0);
        txn(6'b001010, 24'h007000, 6'b001000, 1'b0, 1'b1, 0, 0);
        // Unclaimed cycle: watchdog termination on both instances.
        txn(6'b000000, 24'h000000, 6'b000000, 1'b0, 1'b0, 0, 0);
        // Foreign termination at clock 40 (A aborts, B already timed out).
        txn(6'b000000, 24'h000000, 6'b000000, 1'b0, 1'b0, 40, 0);
        // Foreign termination while counting.
        txn(6'b100000, 24'hF00000, 6'b000000, 1'b0, 1'b0, 5, 0);

        // Delay 14 against limit 15: channel wins, flag stays clear on B.
        do_reset();
        txn(6'b000001, 24'h00000E, 6'b000000, 1'b0, 1'b0, 0, 0);
        // Delay 15 against limit 15: B terminates by watchdog.
        txn(6'b000001, 24'h00000F, 6'b000001, 1'b0, 1'b0, 0, 0);

        // External terminator, with a second TS landing during NEGATE.
        txn(6'b000000, 24'h000000, 6'b000000, 1'b1, 1'b0, 0, 2);

        // Reset asserted in the middle of ASSERT.
        @(negedge CLK40);
        TSn = 1'b0; CH_SEL = 6'b010000; CH_DELAY = 24'h020000; CH_NOCACHE = 6'b010000;
        @(posedge CLK40);
        @(negedge CLK40);
        TSn = 1'b1;
        repeat (3) @(posedge CLK40);
        #2;
        check("mid-assert A", {8'h0, oe_a, tack_a}, 10'b0000000010);
        check("mid-assert B", {8'h0, oe_b, tack_b}, 10'b0000000010);
        DELAYED_TACK_RST = 1'b1;
        #1;
        check_reset_state("async reset");
        @(negedge CLK40);
        DELAYED_TACK_RST = 1'b0;
        mflag_a = 1'b0; mflag_b = 1'b0; ch_m = 4'h0;
        txn(6'b000100, 24'h000300, 6'b000100, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 16; n++) begin
            rsel = ($urandom_range(7) == 0) ? 6'h00 : 6'($urandom_range(63, 1));
            txn(rsel, 24'($urandom), 6'($urandom), 1'b0, 1'($urandom_range(1)), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/u409_tack_engine.md
Name: u409_tack_engine

Overview:
Parametrised successor to U409's single-purpose transfer-ack logic: one engine that terminates MC68040/060 bus cycles for NCH address-space channels. Each channel has its own run-time delay and cache-inhibit attribute. An unclaimed-cycle watchdog and an external-ack merge input are included. The engine drives the shared TACKn/TBIn/TCIn lines through output enables, with a 3-phase assert / negate / release sequence, and sits between U409's address decode and the CPU bus.

Parameters:
NCH, 6, number of termination channels (1..16); channel 0 has highest priority
DW, 4, width of each channel delay field in CLK40 cycles
WDW, 7, watchdog counter width
WD_LIMIT, 125, CLK40 cycles from TS to watchdog termination (must be < 2^WDW)

Ports:
CLK40  in  1  bus clock; all state updates on rising edge
DELAYED_TACK_RST  in  1  reset, asynchronous, active-high
TSn  in  1  CPU transfer start, active low
CH_SEL  in  NCH  per-channel address-space hit, sampled with TSn
CH_DELAY  in  NCH*DW  per-channel delay; channel i at bits [i*DW +: DW]
CH_NOCACHE  in  NCH  1 = drive TCIn low with TACKn for that channel
EXT_TACK  in  1  one-clock request from an external terminator (e.g. autoconfig)
TACKn_IN  in  1  sensed level of the shared TACKn net
TACK_OE  out  1  output enable for TACKn, TBIn and TCIn drivers
TACK_OUTn  out  1  TACKn and TBIn drive value
TCI_OUTn  out  1  TCIn drive value
ACTIVE_CH  out  4  index of the latched channel; valid while BUSY
BUSY  out  1  a cycle is open in the engine
TIMEOUT_FLAG  out  1  sticky; set when the watchdog terminated a cycle

Behaviour:
- Reset values (async on DELAYED_TACK_RST):
  - TACK_OE=0, TACK_OUTn=1, TCI_OUTn=1, BUSY=0, ACTIVE_CH=0, TIMEOUT_FLAG=0.
  - All counters 0, state IDLE.
  - Reset mid-cycle releases the bus immediately (OE=0 asynchronously).
- States: IDLE, COUNT, WAIT, ASSERT, NEGATE, RELEASE.
- IDLE:
  - Edge k, TSn=0 and any CH_SEL bit set: latch the lowest set index i into ACTIVE_CH; cnt=CH_DELAY[i]; BUSY=1; go to COUNT.
  - Edge k, TSn=0 and CH_SEL=0: BUSY=1; go to WAIT.
  - EXT_TACK=1 with TSn=1: go straight to ASSERT.
  - EXT_TACK=1 together with TSn=0: the channel path wins and EXT_TACK is dropped.
- COUNT:
  - cnt==0: go to ASSERT.
  - otherwise cnt decrements by 1 each edge.
  - Result: TACK_OUTn goes low at edge k+1+d for delay d; d=0 gives a 1-clock latency.
- WAIT:
  - Watchdog wd increments from 1 at edge k.
  - TACKn_IN=0 (another device terminated): go to IDLE, BUSY=0, no drive.
  - wd==WD_LIMIT: set TIMEOUT_FLAG; go to ASSERT.
- Watchdog in COUNT:
  - wd also runs in COUNT.
  - If wd reaches WD_LIMIT before cnt reaches 0, the cycle terminates as a timeout.
  - If both happen on the same edge, the channel wins and TIMEOUT_FLAG is not set.
- ASSERT (registered, entered on the edge above):
  - TACK_OE=1, TACK_OUTn=0.
  - TCI_OUTn=0 if CH_NOCACHE[ACTIVE_CH], else 1. Watchdog and EXT_TACK terminations drive TCI_OUTn=0.
  - Held exactly 1 clock, then go to NEGATE.
- NEGATE: TACK_OUTn=1, TCI_OUTn=1, OE stays 1 for 1 clock (actively drives the line high); go to RELEASE.
- RELEASE: OE=0, BUSY=0; go to IDLE. TSn is not sampled in RELEASE, so the minimum gap between terminations is 3 clocks.
- TSn pulses while BUSY are ignored; the engine is not pipelined.
- TACKn_IN low in COUNT while OE=0 (foreign termination): abort to IDLE, no drive.
- CH_DELAY is sampled only at the latch edge; later changes do not affect the open cycle.
- TIMEOUT_FLAG clears only on reset.

Optional Feature:
U409_TEA_ON_TIMEOUT_EN
- Defined: adds output TEA_OUTn (reset 1). A watchdog termination asserts TEA_OUTn=0 under TACK_OE for the ASSERT clock, instead of TACK_OUTn. TACK_OUTn stays 1 for that cycle, and the NEGATE/RELEASE sequence is unchanged.
- Undefined: port absent; a watchdog timeout terminates with a normal TACK.

Test Plan:
- CH_SEL=6'b000100, CH_DELAY[2]=3, TSn low at edge 10 -> TACK_OUTn=0 at edge 14 only; OE=1 for edges 14–15, OE=0 at edge 16; ACTIVE_CH=2.
- CH_SEL=6'b001010, CH_DELAY[1]=0, CH_DELAY[3]=7 -> channel 1 wins; TACK_OUTn low 1 clock after TS; TCI_OUTn follows CH_NOCACHE[1].
- TSn low with CH_SEL=0 and TACKn_IN held high -> TACK at wd=125, TIMEOUT_FLAG=1. Repeat with TACKn_IN pulsed low at clock 40 -> no drive, BUSY=0, flag unchanged.
- CH_DELAY=15 (max), WD_LIMIT=10 -> timeout termination at clock 10. WD_LIMIT=15 with delay 14 reaching 0 on the same edge -> channel wins, no flag.
- EXT_TACK pulse in IDLE -> ASSERT the next edge; a second TSn during NEGATE is ignored.
- DELAYED_TACK_RST pulsed during ASSERT -> OE=0 immediately, all outputs at reset values, next TS handled normally.
